uart_cmd_decoder: RTL and testbench
===================================

// Module: uart_cmd_decoder
// PURPOSE
//  Sits directly downstream of the UART byte receiver. Takes each received byte (data + control strobe) and
//  assembles two-byte request frames from the Raspberry: byte 0 = command code, byte 1 = sensor address.
//  Checks both fields and presents the command to the sensor controller with a valid/ready handshake.
//  Reports malformed frames, inter-byte timeouts and overruns as single-cycle error pulses.
// PARAMETERS
//  NUM_CMDS        7     command codes 0..NUM_CMDS-1 are legal; any other value -> err_cmd
//  ADDR_MAX        31    addresses 0..ADDR_MAX are legal; any other value -> err_addr
//  TIMEOUT_CYCLES  1152  max clk cycles from the byte 0 edge to the byte 1 edge (~10 ms @115200 Hz)
// PORTS
//  clk_115200hz  in   1  clock, same domain as the receiver
//  reset         in   1  synchronous, active-high
//  data          in   8  received byte from the receiver
//  control       in   1  byte-available level from the receiver; high for >=1 cycle per byte
//  cmd           out  4  decoded command code
//  addr          out  5  decoded sensor address
//  cmd_valid     out  1  cmd/addr valid; held until accepted
//  cmd_ready     in   1  consumer accepts when cmd_valid && cmd_ready
//  err_cmd       out  1  1-cycle pulse: illegal command byte
//  err_addr      out  1  1-cycle pulse: illegal address byte
//  err_timeout   out  1  1-cycle pulse: byte 1 missing within TIMEOUT_CYCLES
//  err_overrun   out  1  1-cycle pulse: byte arrived while cmd_valid was pending
//  busy          out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Byte event = rising edge of control (registered control_d; event = control & ~control_d).
//    A level held across several cycles counts as ONE byte. control_d resets to 0.
//  - Reset: all outputs 0; state IDLE; timeout counter 0; control_d 0. Reset mid-frame drops the partial frame.
//  - FSM:
//    IDLE: on a byte event, if data < NUM_CMDS, latch data[3:0] into cmd_q, clear the counter, go to WAIT_ADDR.
//      Otherwise pulse err_cmd and stay in IDLE.
//    WAIT_ADDR: the counter increments every cycle.
//      Byte event with data <= ADDR_MAX: latch data[4:0] into addr, drive cmd <= cmd_q, go to ISSUE.
//      Byte event with data > ADDR_MAX: pulse err_addr, go to IDLE.
//      Counter reaching TIMEOUT_CYCLES-1 with no event: pulse err_timeout, go to IDLE.
//      A byte event in the same cycle as the timeout wins; no err_timeout in that case.
//    ISSUE: cmd_valid=1; cmd/addr stable. When cmd_ready=1, go to IDLE (cmd_valid drops next cycle).
//      A byte event while in ISSUE is discarded and pulses err_overrun; the pending command is unaffected.
//  - Latency: cmd_valid rises 1 cycle after the byte-1 event. Error pulses occur 1 cycle after the cause.
//  - A byte event in the cycle where ISSUE exits on cmd_ready counts as an overrun (not captured).
//  - Counter width = $clog2(TIMEOUT_CYCLES)+1. The counter saturates and never wraps.
//  - cmd and addr keep their last value after the handshake. Only cmd_valid qualifies them.
// CONFIGURATION
//  CMD_DEC_ERRCNT_EN defined: adds output err_count[7:0].
//    Increments on any err_* pulse and saturates at 8'hFF.
//    Reset clears it. input clr_errcnt (1-cycle) clears it; clear wins over a simultaneous increment.
//  Not defined: neither port exists; no counter logic is generated.
// TESTING
//  1. Reset, then bytes 0x02 and 0x05 with cmd_ready=1 -> one cmd_valid cycle with cmd=2, addr=5; no errors.
//  2. Byte 0x09 -> err_cmd pulse, stays IDLE. Then 0x01, 0x20 -> err_addr pulse, back to IDLE, cmd_valid never 1.
//  3. Byte 0x03, then no byte for 1152 cycles -> err_timeout exactly once, busy=0. A later 0x03,0x04 decodes normally.
//  4. 0x01,0x07 with cmd_ready=0, then byte 0x02 -> err_overrun pulse; cmd=1/addr=7 held; ready=1 -> single accept.
//  5. control held high 5 cycles with data=0x04, then 0x06 -> exactly one frame: cmd=4, addr=6.
//  6. reset asserted in WAIT_ADDR, then 0x10 -> err_cmd (no stale frame). With CMD_DEC_ERRCNT_EN: err_count=1; clr_errcnt -> 0.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Assembles {command, address} request frames from UART byte strobes and hands them off via valid/ready.
// Optional feature macro CMD_DEC_ERRCNT_EN adds clr_errcnt input and a saturating err_count[7:0] output.
module uart_cmd_decoder #(
  parameter int NUM_CMDS       = 7,
  parameter int ADDR_MAX       = 31,
  parameter int TIMEOUT_CYCLES = 1152
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       control,
  output logic [3:0] cmd,
  output logic [4:0] addr,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       err_cmd,
  output logic       err_addr,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
`ifdef CMD_DEC_ERRCNT_EN
  ,
  input  logic       clr_errcnt,
  output logic [7:0] err_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [7:0]       CMD_LIM  = 8'(NUM_CMDS);
  localparam logic [7:0]       ADDR_LIM = 8'(ADDR_MAX);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, ISSUE} state_t;

  state_t           state;
  state_t           state_n;
  logic             control_d;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cmd_q;
  logic             byte_ev;
  logic             cmd_ok;
  logic             addr_ok;
  logic             timeout_hit;
  logic             err_cmd_n;
  logic             err_addr_n;
  logic             err_timeout_n;
  logic             err_overrun_n;

  // A level held over several cycles is a single byte: only its rising edge counts.
  assign byte_ev     = control & ~control_d;
  assign cmd_ok      = (data < CMD_LIM);
  assign addr_ok     = (data <= ADDR_LIM);
  assign timeout_hit = (cnt == TMO_LAST);

  always_ff @(posedge clk_115200hz) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (byte_ev && cmd_ok) state_n = WAIT_ADDR;
      WAIT_ADDR: begin
        if (byte_ev)          state_n = addr_ok ? ISSUE : IDLE;
        else if (timeout_hit) state_n = IDLE;
      end
      ISSUE:     if (cmd_ready) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // A byte arriving together with the timeout takes priority over the timeout.
  always_comb begin
    cmd_valid     = (state == ISSUE);
    busy          = (state != IDLE);
    err_cmd_n     = (state == IDLE)      && byte_ev && !cmd_ok;
    err_addr_n    = (state == WAIT_ADDR) && byte_ev && !addr_ok;
    err_timeout_n = (state == WAIT_ADDR) && !byte_ev && timeout_hit;
    err_overrun_n = (state == ISSUE)     && byte_ev;
  end

  always_ff @(posedge clk_115200hz) begin
    if (reset) begin
      control_d   <= 1'b0;
      cnt         <= '0;
      cmd_q       <= '0;
      cmd         <= '0;
      addr        <= '0;
      err_cmd     <= 1'b0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      control_d   <= control;
      err_cmd     <= err_cmd_n;
      err_addr    <= err_addr_n;
      err_timeout <= err_timeout_n;
      err_overrun <= err_overrun_n;

      if (state == IDLE)
        cnt <= '0;
      else if (state == WAIT_ADDR && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      if (state == IDLE && byte_ev && cmd_ok)
        cmd_q <= data[3:0];

      if (state == WAIT_ADDR && byte_ev && addr_ok) begin
        addr <= data[4:0];
        cmd  <= cmd_q;
      end
    end
  end

`ifdef CMD_DEC_ERRCNT_EN
  logic any_err;
  assign any_err = err_cmd | err_addr | err_timeout | err_overrun;

  always_ff @(posedge clk_115200hz) begin
    if (reset || clr_errcnt)
      err_count <= 8'h00;
    else if (any_err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed frame scenarios plus randomized byte traffic checked cycle by cycle
// against a timestamp-based frame model.
module tb_uart_cmd_decoder;

  localparam int TMO = 1152;

  logic       clk_115200hz = 1'b0;
  logic       reset        = 1'b1;
  logic [7:0] data         = 8'h00;
  logic       control      = 1'b0;
  logic       cmd_ready    = 1'b0;
  logic [3:0] cmd;
  logic [4:0] addr;
  logic       cmd_valid;
  logic       err_cmd;
  logic       err_addr;
  logic       err_timeout;
  logic       err_overrun;
  logic       busy;
`ifdef CMD_DEC_ERRCNT_EN
  logic       clr_errcnt = 1'b0;
  logic [7:0] err_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit rand_mode = 1'b0;
  bit chk_on    = 1'b0;

  always #5 clk_115200hz = ~clk_115200hz;

  uart_cmd_decoder dut (
    .clk_115200hz (clk_115200hz),
    .reset        (reset),
    .data         (data),
    .control      (control),
    .cmd          (cmd),
    .addr         (addr),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .err_cmd      (err_cmd),
    .err_addr     (err_addr),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .busy         (busy)
`ifdef CMD_DEC_ERRCNT_EN
    ,
    .clr_errcnt   (clr_errcnt),
    .err_count    (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames tracked by open/pending flags and the cycle stamp of byte 0.
  bit         m_prev, m_open, m_pend;
  int         m_cyc, m_t0, e_cnt;
  logic [3:0] m_fcmd, e_cmd;
  logic [4:0] e_addr;
  logic [3:0] e_err;  // {cmd, addr, timeout, overrun}

  always @(posedge clk_115200hz) begin
    bit ev;
    m_cyc++;
    ev     = control && !m_prev;
    m_prev = control;
    if (reset) begin
      m_prev = 1'b0; m_open = 1'b0; m_pend = 1'b0;
      e_cmd = '0; e_addr = '0; e_err = '0; e_cnt = 0;
    end else begin
`ifdef CMD_DEC_ERRCNT_EN
      if (clr_errcnt)                   e_cnt = 0;
      else if (e_err != 0 && e_cnt < 255) e_cnt++;
`endif
      e_err = '0;
      if (m_pend) begin
        if (ev)        e_err[0] = 1'b1;
        if (cmd_ready) m_pend = 1'b0;
      end else if (m_open) begin
        if (ev) begin
          m_open = 1'b0;
          if (data <= 31) begin
            m_pend = 1'b1; e_cmd = m_fcmd; e_addr = data[4:0];
          end else e_err[2] = 1'b1;
        end else if (m_cyc - m_t0 == TMO) begin
          m_open = 1'b0; e_err[1] = 1'b1;
        end
      end else if (ev) begin
        if (data < 7) begin
          m_open = 1'b1; m_fcmd = data[3:0]; m_t0 = m_cyc;
        end else e_err[3] = 1'b1;
      end
    end
  end

  always @(negedge clk_115200hz) begin
    if (chk_on) begin
      chk("flags", {cmd_valid, busy, err_cmd, err_addr, err_timeout, err_overrun},
                   {m_pend, m_pend | m_open, e_err});
      chk("cmd_addr", {cmd, addr}, {e_cmd, e_addr});
`ifdef CMD_DEC_ERRCNT_EN
      chk("err_count", err_count, e_cnt[7:0]);
`endif
    end
  end

  int n_acc, n_ecmd, n_eaddr, n_etmo, n_eovr;
  int s_acc, s_ecmd, s_eaddr, s_etmo, s_eovr;

  always @(posedge clk_115200hz) begin
    if (cmd_valid && cmd_ready) n_acc++;
    if (err_cmd)     n_ecmd++;
    if (err_addr)    n_eaddr++;
    if (err_timeout) n_etmo++;
    if (err_overrun) n_eovr++;
  end

  task automatic snap();
    s_acc = n_acc; s_ecmd = n_ecmd; s_eaddr = n_eaddr; s_etmo = n_etmo; s_eovr = n_eovr;
  endtask

  function automatic int err_delta();
    return (n_ecmd - s_ecmd) + (n_eaddr - s_eaddr) + (n_etmo - s_etmo) + (n_eovr - s_eovr);
  endfunction

  task automatic tick();
    @(negedge clk_115200hz);
    if (rand_mode) cmd_ready = ($urandom_range(0, 3) != 0);
`ifdef CMD_DEC_ERRCNT_EN
    clr_errcnt = rand_mode && ($urandom_range(0, 29) == 0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    data = b; control = 1'b1;
    idle(hold);
    control = 1'b0;
    idle(gap);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r, hold, gap;
    logic [7:0] b;
    chk_on = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);

    // 1: basic frame
    cmd_ready = 1'b1; snap();
    send(8'h02, 1, 2); send(8'h05, 1, 4);
    chk("t1_accepts", n_acc - s_acc, 1);
    chk("t1_errors", err_delta(), 0);

    // 2: illegal command, then illegal address
    snap();
    send(8'h09, 1, 3);
    chk("t2_err_cmd", n_ecmd - s_ecmd, 1);
    chk("t2_busy", busy, 0);
    send(8'h01, 1, 2); send(8'h20, 1, 3);
    chk("t2_err_addr", n_eaddr - s_eaddr, 1);
    chk("t2_accepts", n_acc - s_acc, 0);

    // 3: timeout, then normal decode
    snap();
    send(8'h03, 1, 1160);
    chk("t3_err_timeout", n_etmo - s_etmo, 1);
    chk("t3_busy", busy, 0);
    send(8'h03, 1, 2); send(8'h04, 1, 4);
    chk("t3_accepts", n_acc - s_acc, 1);
    chk("t3_timeout_once", n_etmo - s_etmo, 1);

    // byte 1 exactly on the last allowed edge, max legal cmd/addr
    snap();
    send(8'h06, 1, TMO - 1); send(8'h1F, 1, 4);
    chk("tb_edge_accept", n_acc - s_acc, 1);
    chk("tb_edge_no_tmo", n_etmo - s_etmo, 0);
    chk("tb_edge_addr", addr, 5'h1F);
    // one cycle later is too late
    snap();
    send(8'h05, 1, TMO); idle(3);
    chk("tc_late_tmo", n_etmo - s_etmo, 1);
    send(8'h03, 1, 2); send(8'h04, 1, 4);
    chk("tc_accepts", n_acc - s_acc, 1);

    // 4: overrun while pending
    cmd_ready = 1'b0; snap();
    send(8'h01, 1, 2); send(8'h07, 1, 3); send(8'h02, 1, 3);
    chk("t4_err_overrun", n_eovr - s_eovr, 1);
    chk("t4_valid", cmd_valid, 1);
    chk("t4_cmd", cmd, 4'd1);
    chk("t4_addr", addr, 5'd7);
    cmd_ready = 1'b1; idle(4);
    chk("t4_accepts", n_acc - s_acc, 1);

    // 5: long control level counts as one byte
    snap();
    data = 8'h04; control = 1'b1; idle(5); control = 1'b0; idle(2);
    send(8'h06, 1, 4);
    chk("t5_accepts", n_acc - s_acc, 1);
    chk("t5_errors", err_delta(), 0);
    chk("t5_cmd", cmd, 4'd4);
    chk("t5_addr", addr, 5'd6);

    // 6: reset mid-frame drops the partial frame
    snap();
    send(8'h03, 1, 5);
    chk("t6_busy", busy, 1);
    reset = 1'b1; idle(2); reset = 1'b0; idle(1);
    send(8'h10, 1, 4);
    chk("t6_err_cmd", n_ecmd - s_ecmd, 1);
    chk("t6_accepts", n_acc - s_acc, 0);
`ifdef CMD_DEC_ERRCNT_EN
    chk("t6_err_count", err_count, 8'd1);
    clr_errcnt = 1'b1; tick(); clr_errcnt = 1'b0; tick();
    chk("t6_err_clear", err_count, 8'd0);
`endif

    // randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      b = 8'($urandom_range(0, 7));
      else if (r < 8) b = 8'($urandom_range(0, 40));
      else            b = 8'($urandom_range(0, 255));
      hold = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 39) == 0) ? $urandom_range(1100, 1200) : $urandom_range(0, 4);
      send(b, hold, gap);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
    end
    rand_mode = 1'b0;
    cmd_ready = 1'b1;
`ifdef CMD_DEC_ERRCNT_EN
    clr_errcnt = 1'b0;
`endif
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
